conf_int_inv_mac__seq: RTL
==========================

CONF_INT_INV_MAC__SEQ -- requirements
Module: conf_int_inv_mac__seq

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 16: width W of every data port and internal datapath register.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  request accepted when high with in_valid at a rising edge.
REQ-006 d, b, c  input  W each  unsigned operands; the block solves d = q*b + c + r for q and r.
REQ-007 out_valid  output  1  result valid.
REQ-008 out_ready  input  1  result consumed when high with out_valid at a rising edge.
REQ-009 q, r  output  W each  unsigned quotient and remainder.
REQ-010 div_by_zero, underflow  output  1 each  error flags qualified by out_valid.

Function
REQ-011 The block SHALL compute diff = (d - c) mod 2^W, q = diff / b, r = diff % b, unsigned, truncated to W bits.
REQ-012 FSM states: IDLE, DIV, DONE; in_ready SHALL be high only in IDLE with rst deasserted.
REQ-013 d, b, c SHALL be sampled only at the accept edge; later changes SHALL be ignored.
REQ-014 Accept edge with b != 0: IDLE->DIV; the divider SHALL perform one restoring shift-subtract step per cycle for exactly W steps, then go to DONE.
REQ-015 Accept edge at edge k, b != 0: out_valid SHALL rise after edge k+W.
REQ-016 Accept with b == 0: IDLE->DONE at the accept edge; out_valid high after edge k+1; q = all ones, r = diff, div_by_zero = 1.
REQ-017 underflow SHALL be 1 when d < c (unsigned) and 0 otherwise; the wrapped diff SHALL still be divided.
REQ-018 DONE SHALL hold q, r and flags stable while out_ready is low, with no limit on stall length.
REQ-019 DONE with out_ready high: DONE->IDLE at that edge; out_valid low the following cycle; no new request accepted on that same edge.
REQ-020 Throughput: at most one request per W+2 cycles (b != 0).
REQ-021 q, r and flags SHALL be zero whenever out_valid is low.

Reset
REQ-022 rst low SHALL immediately, without a clock, force IDLE, out_valid = 0, q = r = 0, flags = 0, and step counter = 0.
REQ-023 Reset during DIV or DONE SHALL discard the in-flight operation; no stale result SHALL appear after release.
REQ-024 The first rising edge with rst high SHALL be able to accept a request.

Configuration
REQ-025 Macro CONF_INT_INV_MAC_ERR_FLAGS_EN defined: div_by_zero and underflow SHALL behave per REQ-016 and REQ-017.
REQ-026 Macro not defined: both ports SHALL remain present and tied to 0; q, r, latency and the b == 0 result values SHALL be unchanged.

Verification (W = 16, macro defined unless stated)
REQ-027 d=100, b=7, c=2 -> q=14, r=0, flags 0, out_valid exactly 16 edges after accept.
REQ-028 d=5, b=3, c=10 -> diff=65531, q=21843, r=2, underflow=1.
REQ-029 d=50, b=0, c=8 -> q=0xFFFF, r=42, div_by_zero=1, out_valid 1 edge after accept; macro undefined -> same q and r, flags 0.
REQ-030 d=0xFFFF, b=1, c=0 with out_ready low for 5 cycles in DONE -> q=0xFFFF, r=0 held stable, in_ready 0 throughout; IDLE one edge after out_ready rises.
REQ-031 rst asserted 8 cycles into DIV -> out_valid 0 and q=r=0 at once; after release, d=100, b=7, c=2 -> q=14, r=0.
REQ-032 Change d, b, c every cycle during DIV -> result matches operands sampled at the accept edge.

Source files
------------

// File: rtl/conf_int_inv_mac__seq.sv
// Sequential solver for d = q*b + c + r: restoring divide of (d - c) mod 2^W by b.
// Define CONF_INT_INV_MAC_ERR_FLAGS_EN to drive div_by_zero/underflow; otherwise both read 0.
module conf_int_inv_mac__seq #(
  parameter int DATA_PATH_BITWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] d,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  input  logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] q,
  output logic [DATA_PATH_BITWIDTH-1:0] r,
  output logic                          div_by_zero,
  output logic                          underflow
);

  localparam int W  = DATA_PATH_BITWIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    dvd_q;      // dividend shifting out, quotient bits shifting in
  logic [W-1:0]    rem_q;
  logic [W-1:0]    dvs_q;
  logic            out_valid_q;
  logic [W-1:0]    q_q;
  logic [W-1:0]    r_q;

  logic            accept;
  logic [W-1:0]    diff_in;
  logic [W:0]      rem_sh;
  logic [W:0]      trial;
  logic [W-1:0]    rem_d;
  logic [W-1:0]    dvd_d;

  assign accept  = in_valid && in_ready;
  assign diff_in = d - c;

  // One restoring step: a borrow out of the (W+1)-bit trial means the divisor did not fit.
  always_comb begin
    rem_sh = {rem_q, dvd_q[W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (trial[W]) begin
      rem_d = rem_sh[W-1:0];
      dvd_d = {dvd_q[W-2:0], 1'b0};
    end else begin
      rem_d = trial[W-1:0];
      dvd_d = {dvd_q[W-2:0], 1'b1};
    end
  end

  // NOTE: asynchronous reset clears every state bit; sequential state uses non-blocking
  // assignments only so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            dvd_q <= diff_in;
            rem_q <= '0;
            dvs_q <= b;
            cnt_q <= '0;
            state_q <= (b == '0) ? S_DONE : S_DIV;
          end
        end
        S_DIV: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            q_q         <= dvd_d;
            r_q         <= rem_d;
          end
        end
        S_DONE: begin
          if (!out_valid_q) begin
            // Only the b == 0 path arrives here without a result; publish it one edge later.
            out_valid_q <= 1'b1;
            q_q         <= '1;
            r_q         <= dvd_q;
          end else if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && rst;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;

`ifdef CONF_INT_INV_MAC_ERR_FLAGS_EN
  logic dbz_q;
  logic ufl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbz_q <= 1'b0;
      ufl_q <= 1'b0;
    end else if (accept) begin
      dbz_q <= (b == '0);
      ufl_q <= (d < c);
    end
  end

  assign div_by_zero = out_valid_q && dbz_q;
  assign underflow   = out_valid_q && ufl_q;
`else
  assign div_by_zero = 1'b0;
  assign underflow   = 1'b0;
`endif

endmodule
